// File: rtl/ahblite_pkg.sv
// -----------------------------------------------------------------------------
// ahblite_pkg
// Shared AHB-Lite definitions for the Cortex-M0 SoC bus decoder:
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HRESP constants (OKAY/ERROR)
//   - default-slave FSM state type (DS_IDLE, DS_ERR1, DS_ERR2)
//   - default region base/mask values used by ahblite_decoder
//   - region_hit() helper for the masked base compare
// No ports (package). Optional feature macro used elsewhere:
//   AHB_DECODER_FAULT_CAPTURE_EN
// -----------------------------------------------------------------------------
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  localparam int NUM_REGIONS = 5;

  localparam logic [31:0] P0_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] P0_MASK_DEF = 32'hE000_0000;
  localparam logic [31:0] P1_BASE_DEF = 32'h2000_0000;
  localparam logic [31:0] P1_MASK_DEF = 32'hE000_0000;
  localparam logic [31:0] P2_BASE_DEF = 32'h4000_0000;
  localparam logic [31:0] P2_MASK_DEF = 32'hFFFF_F000;
  localparam logic [31:0] P3_BASE_DEF = 32'h4000_1000;
  localparam logic [31:0] P3_MASK_DEF = 32'hFFFF_F000;
  localparam logic [31:0] P4_BASE_DEF = 32'h4000_2000;
  localparam logic [31:0] P4_MASK_DEF = 32'hFFFF_F000;

  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/ahblite_decoder_if.sv
// -----------------------------------------------------------------------------
// ahblite_decoder_if
// Bundles the address-phase inputs and the decoder / default-slave outputs.
//   master modport : drives HADDR, HTRANS, HREADY; observes selects + DEF_*
//   slave  modport : the decoder view (inputs address phase, drives selects)
// Signals:
//   HADDR[31:0], HTRANS[1:0], HREADY
//   P0_HSEL..P4_HSEL, DEF_HSEL, DEF_HREADYOUT, DEF_HRESP, DEF_HRDATA[31:0]
// -----------------------------------------------------------------------------
interface ahblite_decoder_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;

  logic        P0_HSEL;
  logic        P1_HSEL;
  logic        P2_HSEL;
  logic        P3_HSEL;
  logic        P4_HSEL;
  logic        DEF_HSEL;
  logic        DEF_HREADYOUT;
  logic        DEF_HRESP;
  logic [31:0] DEF_HRDATA;

  modport master (
    output HADDR, HTRANS, HREADY,
    input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL,
    input  DEF_HSEL, DEF_HREADYOUT, DEF_HRESP, DEF_HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HREADY,
    output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL,
    output DEF_HSEL, DEF_HREADYOUT, DEF_HRESP, DEF_HRDATA
  );
endinterface

// File: rtl/ahblite_default_slave.sv
// -----------------------------------------------------------------------------
// ahblite_default_slave
// Default slave for unmapped space. Returns the two-cycle AHB ERROR response
// (HREADYOUT/HRESP = 0/1 then 1/1) for every accepted active transfer; IDLE
// and BUSY transfers get a zero-wait OKAY.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   sel_i                : DEF_HSEL from the decoder
//   trans_active_i       : HTRANS is NONSEQ or SEQ
//   hready_i             : bus HREADY
//   hreadyout_o, hresp_o : default-slave response
// Optional (AHB_DECODER_FAULT_CAPTURE_EN):
//   haddr_i              : address-phase address
//   fault_addr_o         : address of the last erroring transfer
//   fault_cnt_o          : erroring-transfer count, saturating at 8'hFF
// -----------------------------------------------------------------------------
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sel_i,
  input  logic        trans_active_i,
  input  logic        hready_i,
`ifdef AHB_DECODER_FAULT_CAPTURE_EN
  input  logic [31:0] haddr_i,
  output logic [31:0] fault_addr_o,
  output logic [7:0]  fault_cnt_o,
`endif
  output logic        hreadyout_o,
  output logic        hresp_o
);

  ds_state_e state_q;
  ds_state_e state_d;
  logic      accept;

  // An active unmapped transfer is only taken when the bus is ready.
  assign accept = hready_i & sel_i & trans_active_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    case (state_q)
      DS_IDLE: begin
        if (accept) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        // HREADY is low here, so the address phase is not sampled.
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
        state_d     = DS_ERR2;
      end
      DS_ERR2: begin
        hresp_o = HRESP_ERROR;
        state_d = accept ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        state_d = DS_IDLE;
      end
    endcase
  end

`ifdef AHB_DECODER_FAULT_CAPTURE_EN
  logic [31:0] fault_addr_q;
  logic [7:0]  fault_cnt_q;
  logic        err_start;

  // Entry into ERR1 marks a new erroring transfer; ERR1 itself never accepts.
  assign err_start = accept && (state_q != DS_ERR1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_addr_q <= 32'h0;
      fault_cnt_q  <= 8'h0;
    end else if (err_start) begin
      fault_addr_q <= haddr_i;
      if (fault_cnt_q != 8'hFF) fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign fault_addr_o = fault_addr_q;
  assign fault_cnt_o  = fault_cnt_q;
`endif

endmodule

// File: rtl/ahblite_decoder.sv
// -----------------------------------------------------------------------------
// ahblite_decoder
// AHB-Lite address decoder for the Cortex-M0 SoC bus. Decodes HADDR into
// one-hot selects P0..P4_HSEL (lowest region index wins on overlap) and
// routes anything unmapped to a built-in default slave returning ERROR.
// Ports:
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   bus           : ahblite_decoder_if.slave (HADDR, HTRANS, HREADY in;
//                   P0..P4_HSEL, DEF_HSEL, DEF_HREADYOUT, DEF_HRESP,
//                   DEF_HRDATA out)
// Optional (AHB_DECODER_FAULT_CAPTURE_EN defined):
//   FAULT_ADDR[31:0] : HADDR of the last erroring transfer
//   FAULT_CNT[7:0]   : erroring-transfer count, saturating at 8'hFF
// Parameters: Pn_BASE / Pn_MASK per region, n = 0..4.
// -----------------------------------------------------------------------------
module ahblite_decoder
  import ahblite_pkg::*;
#(
  parameter logic [31:0] P0_BASE = P0_BASE_DEF,
  parameter logic [31:0] P0_MASK = P0_MASK_DEF,
  parameter logic [31:0] P1_BASE = P1_BASE_DEF,
  parameter logic [31:0] P1_MASK = P1_MASK_DEF,
  parameter logic [31:0] P2_BASE = P2_BASE_DEF,
  parameter logic [31:0] P2_MASK = P2_MASK_DEF,
  parameter logic [31:0] P3_BASE = P3_BASE_DEF,
  parameter logic [31:0] P3_MASK = P3_MASK_DEF,
  parameter logic [31:0] P4_BASE = P4_BASE_DEF,
  parameter logic [31:0] P4_MASK = P4_MASK_DEF
)(
  input  logic                HCLK,
  input  logic                HRESETn,
`ifdef AHB_DECODER_FAULT_CAPTURE_EN
  output logic [31:0]         FAULT_ADDR,
  output logic [7:0]          FAULT_CNT,
`endif
  ahblite_decoder_if.slave    bus
);

  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] sel;
  logic                   def_sel;
  logic                   trans_active;

  assign hit[0] = region_hit(bus.HADDR, P0_BASE, P0_MASK);
  assign hit[1] = region_hit(bus.HADDR, P1_BASE, P1_MASK);
  assign hit[2] = region_hit(bus.HADDR, P2_BASE, P2_MASK);
  assign hit[3] = region_hit(bus.HADDR, P3_BASE, P3_MASK);
  assign hit[4] = region_hit(bus.HADDR, P4_BASE, P4_MASK);

  // Priority encode so overlapping regions still yield a single select.
  always_comb begin
    sel     = '0;
    def_sel = 1'b0;
    if (hit[0])      sel[0]  = 1'b1;
    else if (hit[1]) sel[1]  = 1'b1;
    else if (hit[2]) sel[2]  = 1'b1;
    else if (hit[3]) sel[3]  = 1'b1;
    else if (hit[4]) sel[4]  = 1'b1;
    else             def_sel = 1'b1;
  end

  assign bus.P0_HSEL   = sel[0];
  assign bus.P1_HSEL   = sel[1];
  assign bus.P2_HSEL   = sel[2];
  assign bus.P3_HSEL   = sel[3];
  assign bus.P4_HSEL   = sel[4];
  assign bus.DEF_HSEL  = def_sel;
  assign bus.DEF_HRDATA = 32'h0;

  assign trans_active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);

  ahblite_default_slave u_def_slave (
    .clk_i          (HCLK),
    .rst_ni         (HRESETn),
    .sel_i          (def_sel),
    .trans_active_i (trans_active),
    .hready_i       (bus.HREADY),
`ifdef AHB_DECODER_FAULT_CAPTURE_EN
    .haddr_i        (bus.HADDR),
    .fault_addr_o   (FAULT_ADDR),
    .fault_cnt_o    (FAULT_CNT),
`endif
    .hreadyout_o    (bus.DEF_HREADYOUT),
    .hresp_o        (bus.DEF_HRESP)
  );

endmodule

// File: tb/tb_ahblite_decoder.sv
// -----------------------------------------------------------------------------
// tb_ahblite_decoder
// Scoreboard bench for ahblite_decoder. A stimulus process drives one address
// phase per cycle and pushes the expected selects/response from a reference
// model; a monitor pops and compares mid-cycle. A second instance with region 1
// overlapping region 0 checks priority resolution.
// Honours AHB_DECODER_FAULT_CAPTURE_EN for the fault-capture outputs.
// -----------------------------------------------------------------------------
module tb_ahblite_decoder;

  logic HCLK;
  logic HRESETn;

  ahblite_decoder_if bus_if ();
  ahblite_decoder_if ovl_if ();

  assign ovl_if.HADDR  = bus_if.HADDR;
  assign ovl_if.HTRANS = bus_if.HTRANS;
  assign ovl_if.HREADY = bus_if.HREADY;

`ifdef AHB_DECODER_FAULT_CAPTURE_EN
  logic [31:0] fault_addr;
  logic [7:0]  fault_cnt;
  logic [31:0] ovl_fault_addr;
  logic [7:0]  ovl_fault_cnt;
`endif

  ahblite_decoder u_dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
`ifdef AHB_DECODER_FAULT_CAPTURE_EN
    .FAULT_ADDR (fault_addr),
    .FAULT_CNT  (fault_cnt),
`endif
    .bus        (bus_if)
  );

  ahblite_decoder #(
    .P1_BASE (32'h0000_0000),
    .P1_MASK (32'hE000_0000)
  ) u_ovl (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
`ifdef AHB_DECODER_FAULT_CAPTURE_EN
    .FAULT_ADDR (ovl_fault_addr),
    .FAULT_CNT  (ovl_fault_cnt),
`endif
    .bus        (ovl_if)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Region table as written in the memory map.
  logic [31:0] reg_base [5];
  logic [31:0] reg_mask [5];
  initial begin
    reg_base[0] = 32'h0000_0000; reg_mask[0] = 32'hE000_0000;
    reg_base[1] = 32'h2000_0000; reg_mask[1] = 32'hE000_0000;
    reg_base[2] = 32'h4000_0000; reg_mask[2] = 32'hFFFF_F000;
    reg_base[3] = 32'h4000_1000; reg_mask[3] = 32'hFFFF_F000;
    reg_base[4] = 32'h4000_2000; reg_mask[4] = 32'hFFFF_F000;
  end

  typedef struct packed {
    logic [5:0]  sel;
    logic [5:0]  sel2;
    logic        rdy;
    logic        resp;
    logic [31:0] faddr;
    logic [7:0]  fcnt;
  } exp_t;

  exp_t        scb[$];
  logic [1:0]  pend[$];   // future {HREADYOUT,HRESP} data-phase beats
  logic [31:0] m_faddr;
  int          m_fcnt;
  int          checks;
  int          failures;
  bit          mon_en;

  // Select vector {DEF,P4..P0}; first matching region in index order wins.
  function automatic logic [5:0] ref_sel(input logic [31:0] a, input bit ovl);
    logic [5:0]  r;
    logic [31:0] b;
    logic [31:0] m;
    r = 6'b100000;
    for (int i = 4; i >= 0; i--) begin
      b = reg_base[i];
      m = reg_mask[i];
      if (ovl && i == 1) begin
        b = reg_base[0];
        m = reg_mask[0];
      end
      if ((a & m) == b) begin
        r = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // One bus cycle. rst_val is applied with the inputs; rst_mid pulls reset
  // low part-way through the cycle (asynchronous assertion).
  task automatic cycle(input logic [31:0] a, input logic [1:0] t, input logic r,
                       input logic rst_val, input bit rst_mid);
    exp_t       e;
    logic [1:0] cur;
    bit         in_rst;
    bit         acc;
    @(posedge HCLK);
    #1;
    bus_if.HADDR  = a;
    bus_if.HTRANS = t;
    bus_if.HREADY = r;
    HRESETn       = rst_val;
    in_rst = rst_mid || !rst_val;
    e.sel  = ref_sel(a, 1'b0);
    e.sel2 = ref_sel(a, 1'b1);
    acc    = 1'b0;
    if (in_rst) begin
      pend.delete();
      m_faddr = 32'h0;
      m_fcnt  = 0;
      cur     = 2'b10;
    end else begin
      cur = (pend.size() != 0) ? pend.pop_front() : 2'b10;
      acc = r && e.sel[5] && t[1] && (cur != 2'b01);
    end
    e.rdy   = cur[1];
    e.resp  = cur[0];
    e.faddr = m_faddr;
    e.fcnt  = 8'(m_fcnt);
    scb.push_back(e);
    if (acc) begin
      pend.push_back(2'b01);
      pend.push_back(2'b11);
      m_faddr = a;
      if (m_fcnt < 255) m_fcnt++;
    end
    if (rst_mid) begin
      #2;
      HRESETn = 1'b0;
    end
  endtask

  always @(negedge HCLK) begin
    exp_t e;
    if (mon_en) begin
      if (scb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
      end else begin
        e = scb.pop_front();
        chk("sel", 32'({bus_if.DEF_HSEL, bus_if.P4_HSEL, bus_if.P3_HSEL,
                        bus_if.P2_HSEL, bus_if.P1_HSEL, bus_if.P0_HSEL}), 32'(e.sel));
        chk("sel_overlap", 32'({ovl_if.DEF_HSEL, ovl_if.P4_HSEL, ovl_if.P3_HSEL,
                                ovl_if.P2_HSEL, ovl_if.P1_HSEL, ovl_if.P0_HSEL}), 32'(e.sel2));
        chk("hreadyout", 32'(bus_if.DEF_HREADYOUT), 32'(e.rdy));
        chk("hresp", 32'(bus_if.DEF_HRESP), 32'(e.resp));
        chk("hrdata", bus_if.DEF_HRDATA, 32'h0);
`ifdef AHB_DECODER_FAULT_CAPTURE_EN
        chk("fault_addr", fault_addr, e.faddr);
        chk("fault_cnt", 32'(fault_cnt), 32'(e.fcnt));
`endif
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    int          k;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    m_faddr  = 32'h0;
    m_fcnt   = 0;
    HRESETn  = 1'b0;
    bus_if.HADDR  = 32'h4000_1004;
    bus_if.HTRANS = 2'b10;
    bus_if.HREADY = 1'b1;

    // Reset: selects still decode, default slave idle.
    cycle(32'h4000_1004, 2'b10, 1'b1, 1'b0, 1'b0);
    mon_en = 1'b1;
    cycle(32'h9000_0000, 2'b10, 1'b1, 1'b0, 1'b0);
    cycle(32'h4000_1004, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h4000_1004, 2'b10, 1'b1, 1'b1, 1'b0);

    // Single unmapped NONSEQ: ERR1, ERR2, then idle.
    cycle(32'h9000_0000, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);

    // Back-to-back: second transfer issued in the ERR2 cycle.
    cycle(32'h9000_0000, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h9000_0004, 2'b10, 1'b0, 1'b1, 1'b0);
    cycle(32'h9000_0004, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);

    // IDLE / BUSY to unmapped space: zero-wait OKAY.
    cycle(32'h9000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'hF000_0000, 2'b01, 1'b1, 1'b1, 1'b0);
    cycle(32'h4000_3000, 2'b00, 1'b1, 1'b1, 1'b0);

    // Overlap instance and region edges.
    cycle(32'h0000_0010, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h2000_0010, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h1FFF_FFFF, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h4000_0FFC, 2'b11, 1'b1, 1'b1, 1'b0);
    cycle(32'h4000_2FFC, 2'b11, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);

    // Reset asserted during ERR1.
    cycle(32'h9000_0000, 2'b10, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b1);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: a = {3'b000, 29'($urandom)};
        1: a = {3'b001, 29'($urandom)};
        2: a = 32'h4000_0000 | 32'($urandom_range(0, 4095));
        3: a = 32'h4000_1000 | 32'($urandom_range(0, 4095));
        4: a = 32'h4000_2000 | 32'($urandom_range(0, 4095));
        5: a = 32'h4000_3000 | 32'($urandom_range(0, 4095));
        default: a = $urandom;
      endcase
      t = 2'($urandom_range(0, 3));
      cycle(a, t, ($urandom_range(0, 9) < 8), 1'b1, ($urandom_range(0, 99) == 0));
    end
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);

    // 300 back-to-back unmapped transfers, the last at 32'hA000_0040.
    cycle(32'h9000_0000, 2'b10, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 300; i++) begin
      a = (i == 299) ? 32'hA000_0040 : (32'h9000_0000 + 32'(i * 4));
      cycle(a, 2'b10, 1'b0, 1'b1, 1'b0);
      cycle(a, 2'b10, 1'b1, 1'b1, 1'b0);
    end
    cycle(32'h0000_0000, 2'b00, 1'b0, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);
    cycle(32'h0000_0000, 2'b00, 1'b1, 1'b1, 1'b0);

    @(negedge HCLK);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(scb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
